// File: rtl/shim_trigger_timestamp_reader_if.sv
// Timestamp record stream between the trigger FIFO reader and the capture/DMA side.
interface shim_trigger_timestamp_reader_if #(
    parameter int unsigned DELTA_WIDTH = 32
);
    logic                   ts_valid;
    logic                   ts_ready;
    logic [63:0]            ts_time;
    logic [DELTA_WIDTH-1:0] ts_delta;
    logic                   ts_first;

    modport master (
        output ts_valid,
        output ts_time,
        output ts_delta,
        output ts_first,
        input  ts_ready
    );

    modport slave (
        input  ts_valid,
        input  ts_time,
        input  ts_delta,
        input  ts_first,
        output ts_ready
    );
endinterface

// File: rtl/shim_trigger_timestamp_reader.sv
// Pops two-word trigger records from the timestamp FIFO, rebuilds the 64-bit time,
// computes the saturated inter-trigger interval and streams each record downstream.
module shim_trigger_timestamp_reader #(
    parameter int unsigned DELTA_WIDTH  = 32,
    parameter int unsigned PAIR_TIMEOUT = 16
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    output logic                                  data_word_rd_en,
    input  logic [31:0]                           data_word,
    input  logic                                  data_buf_empty,
    input  logic                                  clear,
    shim_trigger_timestamp_reader_if.master       ts,
    output logic [31:0]                           trig_count,
    output logic                                  pair_timeout,
    output logic                                  non_monotonic
);

    localparam int unsigned CNT_W     = $clog2(PAIR_TIMEOUT + 1);
    localparam logic [63:0] DELTA_MAX = (DELTA_WIDTH >= 64) ? {64{1'b1}}
                                                            : ((64'd1 << DELTA_WIDTH) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO_LAT,
        S_WAIT_HI,
        S_HI_LAT,
        S_OUT
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            lo_q, lo_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [63:0]            prev_q, prev_d;
    logic                   first_q, first_d;
    logic [63:0]            time_q, time_d;
    logic [DELTA_WIDTH-1:0] delta_q, delta_d;
    logic                   tfirst_q, tfirst_d;
    logic                   valid_q, valid_d;
    logic [31:0]            count_q, count_d;
    logic                   pt_q, pt_d;
    logic                   nm_q, nm_d;
    logic [63:0]            t_new;
    logic [63:0]            diff;

    // Pops happen only while waiting for a low or a high word; backpressure never pops.
    assign data_word_rd_en = !data_buf_empty && ((state_q == S_IDLE) || (state_q == S_WAIT_HI));

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        prev_d   = prev_q;
        first_d  = first_q;
        time_d   = time_q;
        delta_d  = delta_q;
        tfirst_d = tfirst_q;
        valid_d  = valid_q;
        count_d  = count_q;
        pt_d     = pt_q;
        nm_d     = nm_q;
        t_new    = {data_word, lo_q};
        diff     = t_new - prev_q;

        if (clear) begin
            state_d  = S_IDLE;
            first_d  = 1'b1;
            prev_d   = '0;
            time_d   = '0;
            delta_d  = '0;
            tfirst_d = 1'b0;
            valid_d  = 1'b0;
            count_d  = '0;
            pt_d     = 1'b0;
            nm_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (data_word_rd_en) state_d = S_LO_LAT;
                end
                S_LO_LAT: begin
                    lo_d    = data_word;
                    cnt_d   = CNT_W'(PAIR_TIMEOUT);
                    state_d = S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (!data_buf_empty) begin
                        state_d = S_HI_LAT;
                    end else if (cnt_q == CNT_W'(1)) begin
                        // High word never came: drop the orphan low word.
                        pt_d    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_HI_LAT: begin
                    time_d   = t_new;
                    tfirst_d = first_q;
                    valid_d  = 1'b1;
                    state_d  = S_OUT;
                    if (first_q) begin
                        delta_d = '0;
                    end else if (t_new <= prev_q) begin
                        delta_d = '0;
                        nm_d    = 1'b1;
                    end else if (diff > DELTA_MAX) begin
                        delta_d = '1;
                    end else begin
                        delta_d = DELTA_WIDTH'(diff);
                    end
                end
                S_OUT: begin
                    if (valid_q && ts.ts_ready) begin
                        valid_d = 1'b0;
                        prev_d  = time_q;
                        first_d = 1'b0;
                        if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            lo_q     <= '0;
            cnt_q    <= '0;
            prev_q   <= '0;
            first_q  <= 1'b1;
            time_q   <= '0;
            delta_q  <= '0;
            tfirst_q <= 1'b0;
            valid_q  <= 1'b0;
            count_q  <= '0;
            pt_q     <= 1'b0;
            nm_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            first_q  <= first_d;
            time_q   <= time_d;
            delta_q  <= delta_d;
            tfirst_q <= tfirst_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            pt_q     <= pt_d;
            nm_q     <= nm_d;
        end
    end

    assign ts.ts_valid    = valid_q;
    assign ts.ts_time     = time_q;
    assign ts.ts_delta    = delta_q;
    assign ts.ts_first    = tfirst_q;
    assign trig_count     = count_q;
    assign pair_timeout   = pt_q;
    assign non_monotonic  = nm_q;

endmodule

// File: tb/tb_shim_trigger_timestamp_reader.sv
// Bench for shim_trigger_timestamp_reader: FIFO model, record scoreboard, vector table and corner sequences.
module tb_shim_trigger_timestamp_reader;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [63:0] t;
        logic [31:0] d;
        logic        f;
        logic        nm;
    } vec_t;

    typedef struct {
        logic [63:0] t;
        logic [31:0] d;
        logic        f;
        logic        nm;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        clear = 1'b0;
    logic        rd_en;
    logic [31:0] data_word = '0;
    logic        empty;
    logic [31:0] trig_count;
    logic        pair_timeout;
    logic        non_monotonic;
    logic        rd_seen = 1'b0;

    logic [31:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    exp_t        sb [$];
    vec_t        tbl [9];
    int          total = 0;
    int          bad = 0;

    shim_trigger_timestamp_reader_if #(.DELTA_WIDTH(32)) ts_if ();

    shim_trigger_timestamp_reader #(
        .DELTA_WIDTH  (32),
        .PAIR_TIMEOUT (16)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_word_rd_en (rd_en),
        .data_word       (data_word),
        .data_buf_empty  (empty),
        .clear           (clear),
        .ts              (ts_if),
        .trig_count      (trig_count),
        .pair_timeout    (pair_timeout),
        .non_monotonic   (non_monotonic)
    );

    always #5 clk = ~clk;

    // Standard (non-FWFT) FIFO: data appears after the pop edge; clear flushes it.
    assign empty = (wr_ptr == rd_ptr);
    always @(posedge clk) rd_seen <= rd_en;
    always @(negedge clk) begin
        if (clear) begin
            rd_ptr = wr_ptr;
        end else if (rd_seen && (rd_ptr != wr_ptr)) begin
            data_word = mem[rd_ptr];
            rd_ptr = rd_ptr + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard check on every accepted record.
    always @(negedge clk) begin
        if (resetn && ts_if.ts_valid && ts_if.ts_ready) begin
            if (sb.size() == 0) begin
                total = total + 1;
                bad = bad + 1;
                $display("FAIL unexpected_record: got time %0h expected no record", ts_if.ts_time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rec_time",  ts_if.ts_time, e.t);
                chk("rec_delta", 64'(ts_if.ts_delta), 64'(e.d));
                chk("rec_first", 64'(ts_if.ts_first), 64'(e.f));
                chk("rec_nonmono", 64'(non_monotonic), 64'(e.nm));
                chk("rec_count", 64'(trig_count), 64'(e.cnt));
            end
        end
    end

    task automatic push_words(input logic [31:0] lo, input logic [31:0] hi);
        mem[wr_ptr] = lo;
        mem[wr_ptr + 1] = hi;
        wr_ptr = wr_ptr + 2;
    endtask

    task automatic push_rec(input vec_t v, input int cnt);
        exp_t e;
        e.t = v.t;
        e.d = v.d;
        e.f = v.f;
        e.nm = v.nm;
        e.cnt = 32'(cnt);
        sb.push_back(e);
        push_words(v.lo, v.hi);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || ts_if.ts_valid) && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        total = total + 1;
        if (n >= budget) begin
            bad = bad + 1;
            $display("FAIL drain_timeout: got %0d records pending expected 0", sb.size());
        end
    endtask

    initial begin
        int   n;
        logic seen_valid;
        vec_t v;

        tbl[0] = '{32'h0000_0000, 32'h0, 64'h0_0000_0000, 32'h0000_0000, 1'b1, 1'b0};
        tbl[1] = '{32'h0000_1388, 32'h0, 64'h0_0000_1388, 32'h0000_1388, 1'b0, 1'b0};
        tbl[2] = '{32'h0000_0000, 32'h2, 64'h2_0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[3] = '{32'h0000_0010, 32'h2, 64'h2_0000_0010, 32'h0000_0010, 1'b0, 1'b0};
        tbl[4] = '{32'h0000_0008, 32'h2, 64'h2_0000_0008, 32'h0000_0000, 1'b0, 1'b1};
        tbl[5] = '{32'h0000_0009, 32'h2, 64'h2_0000_0009, 32'h0000_0001, 1'b0, 1'b1};
        tbl[6] = '{32'hFFFF_FFFF, 32'h2, 64'h2_FFFF_FFFF, 32'hFFFF_FFF6, 1'b0, 1'b1};
        tbl[7] = '{32'h0000_0000, 32'h3, 64'h3_0000_0000, 32'h0000_0001, 1'b0, 1'b1};
        tbl[8] = '{32'h0000_0000, 32'h3, 64'h3_0000_0000, 32'h0000_0000, 1'b0, 1'b1};
        ts_if.ts_ready = 1'b1;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(ts_if.ts_valid), 64'd0);
        chk("rst_time", ts_if.ts_time, 64'd0);
        chk("rst_delta", 64'(ts_if.ts_delta), 64'd0);
        chk("rst_first", 64'(ts_if.ts_first), 64'd0);
        chk("rst_count", 64'(trig_count), 64'd0);
        chk("rst_pair_timeout", 64'(pair_timeout), 64'd0);
        chk("rst_nonmono", 64'(non_monotonic), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // First record: pop timing and t+4 latency.
        @(posedge clk); #1;
        push_rec(tbl[0], 0);
        n = 0;
        do begin
            @(negedge clk);
            n = n + 1;
            if (n == 1) chk("rd_en_lo", 64'(rd_en), 64'd1);
            if (n == 2) chk("rd_en_lo_lat", 64'(rd_en), 64'd0);
            if (n == 3) chk("rd_en_hi", 64'(rd_en), 64'd1);
        end while (!ts_if.ts_valid && n < 20);
        chk("first_latency", 64'(n), 64'd5);
        drain(50);
        chk("count_after_first", 64'(trig_count), 64'd1);

        // Table-driven records back to back.
        @(posedge clk); #1;
        for (int i = 1; i < 9; i++) push_rec(tbl[i], i);
        drain(500);
        chk("count_after_table", 64'(trig_count), 64'd9);

        // Orphan low word: timeout, nothing emitted.
        @(posedge clk); #1;
        mem[wr_ptr] = 32'h55;
        wr_ptr = wr_ptr + 1;
        n = 0;
        seen_valid = 1'b0;
        while (!pair_timeout && n < 40) begin
            @(negedge clk);
            n = n + 1;
            if (ts_if.ts_valid) seen_valid = 1'b1;
        end
        chk("timeout_latency", 64'(n), 64'd19);
        chk("timeout_no_valid", 64'(seen_valid), 64'd0);
        chk("timeout_count", 64'(trig_count), 64'd9);

        v = '{32'h0000_0100, 32'h3, 64'h3_0000_0100, 32'h0000_0100, 1'b0, 1'b1};
        @(posedge clk); #1;
        push_rec(v, 9);
        drain(50);
        chk("timeout_sticky", 64'(pair_timeout), 64'd1);
        chk("count_after_timeout", 64'(trig_count), 64'd10);

        // Backpressure: outputs hold, no pops while another pair waits.
        @(posedge clk); #1;
        ts_if.ts_ready = 1'b0;
        push_words(32'h0000_0200, 32'h3);
        push_words(32'h0000_0300, 32'h3);
        n = 0;
        while (!ts_if.ts_valid && n < 20) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("bp_valid", 64'(ts_if.ts_valid), 64'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_time", ts_if.ts_time, 64'h3_0000_0200);
            chk("bp_delta", 64'(ts_if.ts_delta), 64'h100);
            chk("bp_valid_hold", 64'(ts_if.ts_valid), 64'd1);
            chk("bp_rd_en", 64'(rd_en), 64'd0);
        end
        chk("bp_count", 64'(trig_count), 64'd10);

        // Clear while a record is pending.
        @(posedge clk); #1;
        clear = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clr_valid", 64'(ts_if.ts_valid), 64'd0);
        chk("clr_count", 64'(trig_count), 64'd0);
        chk("clr_pair_timeout", 64'(pair_timeout), 64'd0);
        chk("clr_nonmono", 64'(non_monotonic), 64'd0);
        chk("clr_fifo_empty", 64'(empty), 64'd1);

        ts_if.ts_ready = 1'b1;
        v = '{32'h0000_0005, 32'h0, 64'h0_0000_0005, 32'h0000_0000, 1'b1, 1'b0};
        @(posedge clk); #1;
        push_rec(v, 0);
        drain(50);
        chk("count_after_clear", 64'(trig_count), 64'd1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
